div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for the EX stage (MIPS DIV/DIVU). Computes {HI=remainder, LO=quotient}.
//  Requester side of the pipeline stall protocol: raises stallreq, which the stall controller turns into an
//  EX-and-earlier freeze, until the result is ready. EX holds the divide instruction, and therefore start, while stalled.
// PARAMETERS
//  WIDTH  32  operand width; one quotient bit per BUSY cycle
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, synchronous, active-high
//  start       in   1        EX holds a DIV/DIVU; held high while stalled
//  signed_div  in   1        1=DIV (two's complement), 0=DIVU
//  opdata1     in   WIDTH    dividend (rs)
//  opdata2     in   WIDTH    divisor (rt)
//  annul       in   1        flush of EX; abandons any operation in flight
//  result      out  2*WIDTH  [2W-1:W]=remainder (HI), [W-1:0]=quotient (LO)
//  ready       out  1        result valid, one-cycle pulse
//  stallreq    out  1        to stall controller EX stall request input
// BEHAVIOUR
//  Reset: state=IDLE, result=0, ready=0, count=0, all datapath registers=0. rst overrides every other input.
//  States: IDLE, BYZERO, BUSY, DONE (registered).
//  IDLE: start=1 & annul=0 -> latch operands. If opdata2==0 -> BYZERO, else -> BUSY with count=0.
//   Signed operands are latched as magnitudes; the sign of each operand is stored.
//  BYZERO: result=0 -> DONE.
//  BUSY: step: rem'={rem[W-2:0],dvd msb}; if rem'>=dvs subtract and set qbit=1, else qbit=0; count++.
//   After the WIDTH-th step -> DONE, with the sign fix applied on the same edge:
//   quotient is negated if dividend sign != divisor sign; remainder takes the dividend's sign. Unsigned: no fix.
//   Arithmetic is modulo 2^W. Signed 0x80000000 / -1 gives quot=0x80000000, rem=0, with no trap.
//  DONE: ready=1 and result valid for exactly this cycle -> IDLE unconditionally.
//   result holds its value until the next operation completes or reset.
//  annul=1 in any state -> IDLE next cycle, ready stays 0, result is unchanged. annul has priority over start.
//  stallreq = start & ~ready & ~annul (combinational).
//   It is high from the cycle start is first seen through the last BUSY/BYZERO cycle, and low in the DONE cycle.
//  Latency from start seen in IDLE at cycle T: ready at T+WIDTH+1 (T+33 for W=32); divisor 0: ready at T+2.
//  Back-to-back divides: a second start arriving the cycle after DONE is accepted from IDLE with no extra bubble.
//  Operand changes while BUSY are ignored; only the values latched in IDLE are used.
// CONFIGURATION
//  DIV_BYZERO_FLAG_EN defined: adds output dbz (1 bit), reset 0.
//   dbz=1 together with ready when the divisor was 0; otherwise dbz=0.
//  Not defined: the dbz port and its logic are absent. Divide-by-zero is visible only as result=0.
// TESTING
//  1. DIVU 100/7, start held: stallreq=1 for T..T+32; at T+33 ready=1, stallreq=0, LO=14, HI=2.
//  2. DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2: LO=0xFFFFFFFD, HI=1.
//  3. DIVU 5/0: BYZERO path, ready at T+2, result=0. With DIV_BYZERO_FLAG_EN, dbz=1 for that cycle.
//  4. annul at T+10 mid-BUSY: IDLE at T+11, no ready pulse, result keeps the prior value, stallreq=0.
//  5. Back-to-back: DIVU 9/3, then DIVU 0xFFFFFFFF/16 started the cycle after DONE.
//   Ready pulses 34 cycles apart, results {0,3} then {15,0x0FFFFFFF}.
//  6. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. rst asserted mid-BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces one quotient bit per BUSY cycle and holds the pipeline with stallreq
// until the result is ready. result = {remainder (HI), quotient (LO)}.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       EX holds a DIV/DIVU (held high while stalled)
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   opdata1     dividend (rs)
//   opdata2     divisor (rt)
//   annul       EX flush; abandons any operation in flight
//   result      {remainder, quotient}, held until the next completion
//   ready       one-cycle result-valid pulse
//   stallreq    EX stall request to the stall controller
//   dbz         divide-by-zero flag with ready (only with DIV_BYZERO_FLAG_EN)
//
// Build option: define DIV_BYZERO_FLAG_EN to add the dbz output.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
`ifdef DIV_BYZERO_FLAG_EN
  output logic               dbz,
`endif
  output logic               stallreq
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StByZero, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
`ifdef DIV_BYZERO_FLAG_EN
  logic               dbz_q, dbz_d;
`endif

  // One restoring step. The partial remainder stays below 2^(WIDTH-1) until
  // the final shift, so dropping rem_q's MSB never loses information.
  logic [WIDTH-1:0] rem_shift, rem_step, quot_step;
  logic             qbit;

  always_comb begin
    rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    qbit      = (rem_shift >= dvs_q);
    rem_step  = qbit ? (rem_shift - dvs_q) : rem_shift;
    quot_step = {quot_q[WIDTH-2:0], qbit};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
`ifdef DIV_BYZERO_FLAG_EN
    dbz_d      = dbz_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Magnitudes are latched; 0x80000000 maps to itself, which is the
          // correct unsigned magnitude 2^(WIDTH-1).
          dvd_d      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
          dvs_d      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
          neg_quot_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          neg_rem_d  = signed_div & opdata1[WIDTH-1];
          rem_d      = '0;
          quot_d     = '0;
          count_d    = '0;
          state_d    = (opdata2 == '0) ? StByZero : StBusy;
        end
      end
      StByZero: begin
        result_d = '0;
`ifdef DIV_BYZERO_FLAG_EN
        dbz_d    = 1'b1;
`endif
        state_d  = StDone;
      end
      StBusy: begin
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d   = rem_step;
        quot_d  = quot_step;
        count_d = count_q + 1'b1;
        if (count_q == LastStep) begin
          // Sign fix lands on the same edge as the last step.
          result_d = {(neg_rem_q  ? -rem_step  : rem_step),
                      (neg_quot_q ? -quot_step : quot_step)};
`ifdef DIV_BYZERO_FLAG_EN
          dbz_d    = 1'b0;
`endif
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A flush abandons the operation and leaves the visible result alone.
    if (annul) begin
      state_d  = StIdle;
      result_d = result_q;
`ifdef DIV_BYZERO_FLAG_EN
      dbz_d    = dbz_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
`ifdef DIV_BYZERO_FLAG_EN
      dbz_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
`ifdef DIV_BYZERO_FLAG_EN
      dbz_q      <= dbz_d;
`endif
    end
  end

  always_comb begin
    result   = result_q;
    ready    = (state_q == StDone) && !annul;
    stallreq = start & ~ready & ~annul;
`ifdef DIV_BYZERO_FLAG_EN
    dbz      = ready & dbz_q;
`endif
  end

endmodule
